// File: rtl/colparity_stream.sv
`default_nettype none
// ============================================================================
//  Module      : colparity_stream
//  Description : Streaming column-parity (theta-style) mixer. Accepts one
//                ROWS x COLS slice per handshake over a DEPTH-slice frame and
//                emits each slice XORed with its mixed column parities.
//                The block keeps its own neighbour-slice parity, so callers
//                never supply the previous slice.
//
//                Output order is 1, 2, ..., DEPTH-1, 0. Slice 0 needs the
//                parity of slice DEPTH-1, so it is parked in a holding
//                register and emitted last.
//
//  Ports       : clk, rst        - clock (rising edge), synchronous reset (high)
//                start           - begin a frame (sampled only when idle)
//                in_valid/ready  - input slice handshake, in_data = slice z
//                out_valid/ready - output handshake, out_data / out_idx
//                co_last         - pulse after slice DEPTH-1 is accepted
//                done            - pulse after the slice 0 output handshake
//                out_par         - column parity of the output slice's input
//                                  (only with COLPARITY_PAR_OUT_EN defined)
//
//  Options     : `define COLPARITY_PAR_OUT_EN adds the out_par port.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module colparity_stream #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*COLS-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROWS*COLS-1:0]       out_data,
    output logic [$clog2(DEPTH)-1:0]   out_idx,
`ifdef COLPARITY_PAR_OUT_EN
    output logic [COLS-1:0]            out_par,
`endif
    output logic                       co_last,
    output logic                       done
);

    localparam int                 N          = ROWS * COLS;
    localparam int                 IDX_W      = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(DEPTH - 1);

    // S_DRAIN waits for the slice 0 result to be taken before going idle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Column parity: C[x] = XOR over y of bit (COLS*y + x).
    // ------------------------------------------------------------------------
    function automatic logic [COLS-1:0] col_parity(input logic [N-1:0] s);
        logic [COLS-1:0] c;
        c = '0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                c[x] = c[x] ^ s[COLS*y + x];
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Mix: D[x] = C_cur[x-1] ^ C_prev[x+1] (mod COLS); out = s ^ D per column.
    // ------------------------------------------------------------------------
    function automatic logic [N-1:0] theta_mix(input logic [N-1:0]    s,
                                               input logic [COLS-1:0] cur_c,
                                               input logic [COLS-1:0] prev_c);
        logic [COLS-1:0] d;
        logic [N-1:0]    r;
        d = '0;
        r = '0;
        for (int x = 0; x < COLS; x++) begin
            d[x] = cur_c[(x + COLS - 1) % COLS] ^ prev_c[(x + 1) % COLS];
        end
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                r[COLS*y + x] = s[COLS*y + x] ^ d[x];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [IDX_W-1:0]   r_in_cnt;
    logic [N-1:0]       r_hold0;
    logic [COLS-1:0]    r_prev_c;
    logic               r_out_valid;
    logic [N-1:0]       r_out_data;
    logic [IDX_W-1:0]   r_out_idx;
    logic               r_co_last;
    logic               r_done;

    // ------------------------------------------------------------------------
    // Handshake and load decode
    // ------------------------------------------------------------------------
    logic               w_in_ready;
    logic               w_in_acc;
    logic               w_out_hs;
    logic               w_out_free;
    logic [COLS-1:0]    w_in_c;
    logic [COLS-1:0]    w_h0_c;
    logic               w_load_run;
    logic               w_load_flush;
    logic               w_load;
    logic [N-1:0]       w_load_data;
    logic [IDX_W-1:0]   w_load_idx;

    // The output register is free if empty or being drained this cycle.
    assign w_out_free   = !r_out_valid || out_ready;
    assign w_in_ready   = (r_state == S_RUN) && w_out_free;
    assign w_in_acc     = in_valid && w_in_ready;
    assign w_out_hs     = r_out_valid && out_ready;

    assign w_in_c       = col_parity(in_data);
    assign w_h0_c       = col_parity(r_hold0);

    // Slice 0 is only parked; slices 1..DEPTH-1 produce a result at once.
    assign w_load_run   = w_in_acc && (r_in_cnt != '0);
    assign w_load_flush = (r_state == S_FLUSH) && w_out_free;
    assign w_load       = w_load_run || w_load_flush;

    // In FLUSH r_prev_c holds C of slice DEPTH-1, the wrap neighbour of slice 0.
    assign w_load_data  = w_load_flush ? theta_mix(r_hold0, w_h0_c, r_prev_c)
                                       : theta_mix(in_data, w_in_c, r_prev_c);
    assign w_load_idx   = w_load_flush ? '0 : r_in_cnt;

    // ------------------------------------------------------------------------
    // Control FSM and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_cnt    <= '0;
            r_hold0     <= '0;
            r_prev_c    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_co_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_co_last <= 1'b0;
            r_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_in_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_in_acc) begin
                        r_prev_c <= w_in_c;
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_in_cnt == '0) begin
                            r_hold0 <= in_data;
                        end
                        if (r_in_cnt == c_LAST_IDX) begin
                            r_state   <= S_FLUSH;
                            r_in_cnt  <= '0;
                            r_co_last <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_out_free) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
                r_out_idx   <= w_load_idx;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef COLPARITY_PAR_OUT_EN
    // Parity of the slice that produced the current output, kept in step
    // with out_data.
    logic [COLS-1:0] r_out_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_par <= '0;
        end else if (w_load) begin
            r_out_par <= w_load_flush ? w_h0_c : w_in_c;
        end
    end

    assign out_par = r_out_par;
`else
    // Parity output not built.
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign co_last   = r_co_last;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_colparity_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_colparity_stream
//  Description : Self-checking bench for colparity_stream. Frames are built
//                in an array, driven with selectable backpressure, and every
//                output is compared with a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_colparity_stream;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int DEPTH = 64;
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(DEPTH);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N-1:0]       in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [N-1:0]       out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               co_last;
    logic               done;
`ifdef COLPARITY_PAR_OUT_EN
    logic [COLS-1:0]    out_par;
`endif

    colparity_stream #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
`ifdef COLPARITY_PAR_OUT_EN
        .out_par   (out_par),
`endif
        .co_last   (co_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------------
    // Frame under test and reference model
    // ------------------------------------------------------------------------
    logic [N-1:0] frm [DEPTH];

    function automatic logic ref_c(input int x, input int z);
        logic p;
        p = 1'b0;
        for (int y = 0; y < ROWS; y++) p = p ^ frm[z][COLS*y + x];
        return p;
    endfunction

    function automatic logic [COLS-1:0] ref_par(input int z);
        logic [COLS-1:0] c;
        for (int x = 0; x < COLS; x++) c[x] = ref_c(x, z);
        return c;
    endfunction

    function automatic logic [N-1:0] ref_out(input int z);
        logic [N-1:0] r;
        logic         d;
        for (int x = 0; x < COLS; x++) begin
            d = ref_c((x + COLS - 1) % COLS, z) ^ ref_c((x + 1) % COLS, (z + DEPTH - 1) % DEPTH);
            for (int y = 0; y < ROWS; y++) r[COLS*y + x] = frm[z][COLS*y + x] ^ d;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Output monitor (samples at the falling edge)
    // ------------------------------------------------------------------------
    typedef struct {
        int              idx;
        logic [N-1:0]    data;
        logic [COLS-1:0] par;
    } obs_t;

    obs_t         out_q[$];
    int           co_cnt, done_cnt, acc_cnt, stable_err, ready_err;
    int           done_cyc, last_hs_cyc, start_cyc;
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_data;
    logic [IDX_W-1:0] prev_idx;

    always @(negedge clk) begin
        obs_t o;
        if (out_valid && out_ready) begin
            o.idx  = int'(out_idx);
            o.data = out_data;
`ifdef COLPARITY_PAR_OUT_EN
            o.par  = out_par;
`else
            o.par  = '0;
`endif
            out_q.push_back(o);
            last_hs_cyc = cyc;
        end
        if (co_last) co_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_valid && in_ready) acc_cnt++;
        if (prev_stall && (!out_valid || out_data !== prev_data || out_idx !== prev_idx)) stable_err++;
        if (in_ready && out_valid && !out_ready) ready_err++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
    end

    task automatic clear_mon();
        out_q.delete();
        co_cnt = 0; done_cnt = 0; acc_cnt = 0; stable_err = 0; ready_err = 0;
        done_cyc = -1; last_hs_cyc = -1;
    endtask

    function automatic logic [N-1:0] find_data(input int idx);
        foreach (out_q[i]) if (out_q[i].idx == idx) return out_q[i].data;
        return '1;
    endfunction

    // ------------------------------------------------------------------------
    // Frame driver. mode 0: full rate; 1: out_ready low 10 cycles mid-frame;
    // 2: random in_valid/out_ready, stray start in RUN, stray in_valid after.
    // ------------------------------------------------------------------------
    task automatic run_frame(input int mode, input string name);
        int   ptr;
        logic acc;
        logic timed_out;
        ptr = 0;
        timed_out = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; start_cyc = cyc; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            case (mode)
                0: begin in_valid = (ptr < DEPTH); out_ready = 1'b1; end
                1: begin in_valid = (ptr < DEPTH); out_ready = !(k >= 20 && k < 30); end
                default: begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 1) != 0);
                    start     = (ptr > 0 && ptr < DEPTH) ? ($urandom_range(0, 3) == 0) : 1'b0;
                end
            endcase
            in_data = (ptr < DEPTH) ? frm[ptr] : N'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (acc && ptr < DEPTH) ptr++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL %s timeout: done not seen, slices sent=%0d required=%0d", name, ptr, DEPTH);
        end
    endtask

    task automatic check_frame(input string name);
        int   exp_idx;
        logic [N-1:0] exp_d;
        checks++;
        if (out_q.size() != DEPTH) begin
            failures++;
            $display("FAIL %s out_count: got %0d expected %0d", name, out_q.size(), DEPTH);
        end
        for (int i = 0; i < out_q.size() && i < DEPTH; i++) begin
            exp_idx = (i == DEPTH - 1) ? 0 : i + 1;
            exp_d   = ref_out(exp_idx);
            checks++;
            if (out_q[i].idx != exp_idx || out_q[i].data !== exp_d) begin
                failures++;
                $display("FAIL %s out[%0d]: got idx=%0d data=%07h expected idx=%0d data=%07h",
                         name, i, out_q[i].idx, out_q[i].data, exp_idx, exp_d);
            end
`ifdef COLPARITY_PAR_OUT_EN
            checks++;
            if (out_q[i].par !== ref_par(exp_idx)) begin
                failures++;
                $display("FAIL %s par[idx %0d]: got %b expected %b", name, exp_idx, out_q[i].par, ref_par(exp_idx));
            end
`endif
        end
        checks++;
        if (co_cnt != 1) begin
            failures++;
            $display("FAIL %s co_last_pulses: got %0d expected 1", name, co_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            failures++;
            $display("FAIL %s done: got pulses=%0d at cyc %0d expected 1 at cyc %0d",
                     name, done_cnt, done_cyc, last_hs_cyc + 1);
        end
        checks++;
        if (acc_cnt != DEPTH) begin
            failures++;
            $display("FAIL %s accepted: got %0d expected %0d", name, acc_cnt, DEPTH);
        end
        checks++;
        if (stable_err != 0 || ready_err != 0) begin
            failures++;
            $display("FAIL %s stall_rules: got unstable=%0d ready_while_full=%0d expected 0 0",
                     name, stable_err, ready_err);
        end
    endtask

    task automatic random_frame();
        for (int z = 0; z < DEPTH; z++) frm[z] = N'($urandom);
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_idx !== '0 || co_last !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got in_ready=%b out_valid=%b out_data=%07h out_idx=%0d co_last=%b done=%b expected all 0",
                     in_ready, out_valid, out_data, out_idx, co_last, done);
        end
`ifdef COLPARITY_PAR_OUT_EN
        checks++;
        if (out_par !== '0) begin
            failures++;
            $display("FAIL reset_par: got %b expected 0", out_par);
        end
`endif
        rst = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_in_ready: got %b expected 0", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_frame();
        for (int z = 0; z < DEPTH; z++) frm[z] = '0;
        run_frame(0, "zero");
        check_frame("zero");
    endtask

    task automatic test_single_bit(input int zb, input string name);
        for (int z = 0; z < DEPTH; z++) frm[z] = '0;
        frm[zb] = N'(1);
        run_frame(0, name);
        check_frame(name);
        checks++;
        if (find_data(zb) !== 25'h0210843) begin
            failures++;
            $display("FAIL %s idx%0d: got %07h expected 0210843", name, zb, find_data(zb));
        end
        checks++;
        if (find_data((zb + 1) % DEPTH) !== 25'h1084210) begin
            failures++;
            $display("FAIL %s idx%0d: got %07h expected 1084210", name, (zb + 1) % DEPTH,
                     find_data((zb + 1) % DEPTH));
        end
`ifdef COLPARITY_PAR_OUT_EN
        foreach (out_q[i]) begin
            checks++;
            if (out_q[i].par !== ((out_q[i].idx == zb) ? 5'b00001 : 5'b00000)) begin
                failures++;
                $display("FAIL %s par_idx%0d: got %b", name, out_q[i].idx, out_q[i].par);
            end
        end
`endif
    endtask

    task automatic test_full_rate_random();
        random_frame();
        run_frame(0, "full_rate");
        check_frame("full_rate");
        // start cycle s -> last slice accepted s+DEPTH -> slice 0 shown s+DEPTH+2 -> done s+DEPTH+3
        checks++;
        if (done_cyc - start_cyc != DEPTH + 3) begin
            failures++;
            $display("FAIL full_rate_latency: got %0d cycles expected %0d", done_cyc - start_cyc, DEPTH + 3);
        end
    endtask

    task automatic test_backpressure();
        random_frame();
        run_frame(1, "backpressure");
        check_frame("backpressure");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            random_frame();
            run_frame(2, "random_stall");
            check_frame("random_stall");
        end
    endtask

    task automatic test_midframe_reset();
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || co_last !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: got out_valid=%b in_ready=%b co_last=%b done=%b expected 0",
                     out_valid, in_ready, co_last, done);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        random_frame();
        run_frame(0, "after_reset");
        check_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single_bit(5, "bit_slice5");
        test_single_bit(DEPTH - 1, "bit_wrap");
        test_full_rate_random();
        test_backpressure();
        test_back_to_back();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
